// File: rtl/pl_alu_pkg.sv
// Shared types and constants for the multi-cycle EX-stage ALU.
package pl_alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_LAND = 4'd6,
        OP_LOR  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_CMP  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIVU = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_t;

    // Opcodes that need the iterative datapath; a zero divisor resolves immediately.
    function automatic logic is_iter(input logic [ALU_OP_W-1:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIVU) && !divisor_zero);
    endfunction

endpackage

// File: rtl/pl_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo present the value of the step being taken, so the caller can
// register the final result on the cycle where done is high.
module pl_alu_muldiv
    import pl_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   b_r;
    md_mode_t           mode_r;

    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;

    // One multiply or divide step on the accumulator ({hi, lo} / {remainder, quotient}).
    always_comb begin
        acc_nxt_s = acc_r;
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
        ge_s      = (shifted_s >= {1'b0, b_r});
        diff_s    = shifted_s[WIDTH-1:0] - b_r;
        case (mode_r)
            MD_MUL:  acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
            MD_DIV:  acc_nxt_s = {(ge_s ? diff_s : shifted_s[WIDTH-1:0]), acc_r[WIDTH-2:0], ge_s};
            default: acc_nxt_s = acc_r;
        endcase
    end

    // Operand load on start, then one step per cycle while the counter runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            acc_r  <= {(2*WIDTH){1'b0}};
            b_r    <= {WIDTH{1'b0}};
            mode_r <= MD_MUL;
        end else if (start) begin
            cnt_r  <= CW'(WIDTH);
            acc_r  <= {{WIDTH{1'b0}}, a};
            b_r    <= b;
            mode_r <= mode;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r  <= cnt_r - CW'(1);
            acc_r  <= acc_nxt_s;
        end
    end

    assign done = (cnt_r == CW'(1));
    assign hi   = acc_nxt_s[2*WIDTH-1:WIDTH];
    assign lo   = acc_nxt_s[WIDTH-1:0];

endmodule

// File: rtl/pl_alu_mc.sv
// Multi-cycle EX-stage ALU: handshake FSM, single-cycle datapath and result registers.
module pl_alu_mc
    import pl_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    op1,
    input  logic [WIDTH-1:0]    op2,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    dout,
    output logic [WIDTH-1:0]    dout_hi,
    output logic                cout,
    output logic                comp_gt,
    output logic                comp_lt,
    output logic                comp_eq,
    output logic                err
);

    localparam int AW = $clog2(WIDTH);

    alu_state_t       state_r, state_nxt_s;
    logic             accept_s, is_iter_s, md_done_s;
    md_mode_t         mode_s;
    logic [WIDTH-1:0] md_hi_s, md_lo_s;

    logic [WIDTH:0]   sum_s, dif_s, shl_s, shr_s;
    logic [AW-1:0]    amt_s;
    logic [WIDTH-1:0] res_s, res_hi_s;
    logic             cout_s, gt_s, lt_s, eq_s, err_s;

    assign in_ready  = (state_r == IDLE);
    assign accept_s  = in_valid && in_ready;
    assign is_iter_s = is_iter(op, op2 == {WIDTH{1'b0}});
    assign mode_s    = (op == OP_DIVU) ? MD_DIV : MD_MUL;

    pl_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept_s && is_iter_s),
        .mode  (mode_s),
        .a     (op1),
        .b     (op2),
        .done  (md_done_s),
        .hi    (md_hi_s),
        .lo    (md_lo_s)
    );

    // Single-cycle results, computed at WIDTH+1 bits so the top bit is the carry / no-borrow.
    always_comb begin
        amt_s    = op2[AW-1:0];
        sum_s    = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, carry_in};
        dif_s    = {1'b0, op1} + {1'b0, ~op2} + (WIDTH+1)'(1);
        shl_s    = {1'b0, op1} << amt_s;
        shr_s    = {op1, 1'b0} >> amt_s;
        res_s    = {WIDTH{1'b0}};
        res_hi_s = {WIDTH{1'b0}};
        cout_s   = 1'b0;
        gt_s     = 1'b0;
        lt_s     = 1'b0;
        eq_s     = 1'b0;
        err_s    = 1'b0;
        case (op)
            OP_ADD:  begin res_s = sum_s[WIDTH-1:0]; cout_s = sum_s[WIDTH]; end
            OP_SUB:  begin res_s = dif_s[WIDTH-1:0]; cout_s = dif_s[WIDTH]; end
            OP_AND:  res_s = op1 & op2;
            OP_OR:   res_s = op1 | op2;
            OP_XOR:  res_s = op1 ^ op2;
            OP_NOT:  res_s = ~op1;
            OP_LAND: res_s = WIDTH'((op1 != {WIDTH{1'b0}}) && (op2 != {WIDTH{1'b0}}));
            OP_LOR:  res_s = WIDTH'((op1 != {WIDTH{1'b0}}) || (op2 != {WIDTH{1'b0}}));
            OP_SHL:  begin res_s = shl_s[WIDTH-1:0]; cout_s = shl_s[WIDTH]; end
            OP_SHR:  begin res_s = shr_s[WIDTH:1];   cout_s = shr_s[0];     end
            OP_CMP:  begin
                res_s  = dif_s[WIDTH-1:0];
                cout_s = dif_s[WIDTH];
                gt_s   = (op1 > op2);
                lt_s   = (op1 < op2);
                eq_s   = (op1 == op2);
            end
            OP_MUL:  res_s = {WIDTH{1'b0}};
            OP_DIVU: begin
                // Only reaches the result registers for a zero divisor.
                res_s    = {WIDTH{1'b1}};
                res_hi_s = op1;
                err_s    = 1'b1;
            end
            default: err_s = 1'b1;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: IDLE -> BUSY/DONE on accept, BUSY -> DONE on last step, DONE -> IDLE on handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = is_iter_s ? BUSY : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (md_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Result registers: loaded on a single-cycle accept or on the final iterative step, held until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= {WIDTH{1'b0}};
            dout_hi   <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            comp_gt   <= 1'b0;
            comp_lt   <= 1'b0;
            comp_eq   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && !is_iter_s) begin
                        out_valid <= 1'b1;
                        dout      <= res_s;
                        dout_hi   <= res_hi_s;
                        cout      <= cout_s;
                        comp_gt   <= gt_s;
                        comp_lt   <= lt_s;
                        comp_eq   <= eq_s;
                        err       <= err_s;
                    end
                end
                BUSY: begin
                    if (md_done_s) begin
                        out_valid <= 1'b1;
                        dout      <= md_lo_s;
                        dout_hi   <= md_hi_s;
                        cout      <= 1'b0;
                        comp_gt   <= 1'b0;
                        comp_lt   <= 1'b0;
                        comp_eq   <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_alu_mc.sv
// Scoreboard bench for pl_alu_mc at WIDTH=8 and WIDTH=16.
module tb_pl_alu_mc;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] hi;
        logic        c;
        logic        gt;
        logic        lt;
        logic        eq;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, ir8, ov8, or8, c8, co8, gt8, lt8, eq8, er8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, d8, h8;

    logic        iv16, ir16, ov16, or16, c16, co16, gt16, lt16, eq16, er16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, d16, h16;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    pl_alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .op1(a8), .op2(b8), .carry_in(c8), .out_valid(ov8), .out_ready(or8),
        .dout(d8), .dout_hi(h8), .cout(co8), .comp_gt(gt8), .comp_lt(lt8),
        .comp_eq(eq8), .err(er8)
    );

    pl_alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .op1(a16), .op2(b16), .carry_in(c16), .out_valid(ov16), .out_ready(or16),
        .dout(d16), .dout_hi(h16), .cout(co16), .comp_gt(gt16), .comp_lt(lt16),
        .comp_eq(eq16), .err(er16)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] d, input logic [15:0] hi,
                                input logic c, input logic gt, input logic lt,
                                input logic eq, input logic e);
        return {d, hi, c, gt, lt, eq, e};
    endfunction

    function automatic exp_t act(input bit sel);
        if (sel) return {d16, h16, co16, gt16, lt16, eq16, er16};
        else     return {8'h00, d8, 8'h00, h8, co8, gt8, lt8, eq8, er8};
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? ov16 : ov8;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? ir16 : ir8;
    endfunction

    // Reference model for the 8-bit instance.
    function automatic exp_t model8(input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic c);
        exp_t e;
        logic [8:0]  t;
        logic [15:0] p;
        int s;
        e = '0;
        s = int'(b[2:0]);
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b} + {8'd0, c}; e.d = {8'd0, t[7:0]}; e.c = t[8]; end
            4'd1: begin e.d = {8'd0, a - b}; e.c = (a >= b); end
            4'd2: e.d = {8'd0, a & b};
            4'd3: e.d = {8'd0, a | b};
            4'd4: e.d = {8'd0, a ^ b};
            4'd5: e.d = {8'd0, ~a};
            4'd6: e.d = {15'd0, (a != 8'd0) && (b != 8'd0)};
            4'd7: e.d = {15'd0, (a != 8'd0) || (b != 8'd0)};
            4'd8: begin e.d = {8'd0, a << s}; e.c = (s == 0) ? 1'b0 : a[8 - s]; end
            4'd9: begin e.d = {8'd0, a >> s}; e.c = (s == 0) ? 1'b0 : a[s - 1]; end
            4'd10: begin
                e.d = {8'd0, a - b}; e.c = (a >= b);
                e.gt = (a > b); e.lt = (a < b); e.eq = (a == b);
            end
            4'd11: begin p = a * b; e.d = {8'd0, p[7:0]}; e.hi = {8'd0, p[15:8]}; end
            4'd12: begin
                if (b == 8'd0) begin e.d = 16'h00FF; e.hi = {8'd0, a}; e.e = 1'b1; end
                else begin e.d = {8'd0, a / b}; e.hi = {8'd0, a % b}; end
            end
            default: e.e = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic c);
        if (sel) begin iv16 = v; op16 = op; a16 = a; b16 = b; c16 = c; end
        else begin iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; c8 = c; end
    endtask

    task automatic set_ordy(input bit sel, input logic v);
        if (sel) or16 = v; else or8 = v;
    endtask

    // Issue one op, check latency, busy behaviour, result, optional hold and handshake.
    task automatic run(input bit sel, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic c, input exp_t e,
                       input int exp_lat, input int hold, input string name);
        int lat;
        bit busy_ok;
        exp_t want, got, now;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b, c);
        lat = 0;
        while (!rdy(sel) && lat < 50) begin @(negedge clk); lat++; end
        q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        lat = 1;
        busy_ok = 1'b1;
        while (!vld(sel) && lat < 40) begin
            if (rdy(sel)) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        want = q.pop_front();
        tests++;
        if (!busy_ok) begin fails++; $display("FAIL %s in_ready: got 1 while busy, want 0", name); end
        tests++;
        if (lat !== exp_lat) begin fails++; $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat); end
        got = act(sel);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s result: got d=%h hi=%h c=%b gt=%b lt=%b eq=%b err=%b, want d=%h hi=%h c=%b gt=%b lt=%b eq=%b err=%b",
                     name, got.d, got.hi, got.c, got.gt, got.lt, got.eq, got.e,
                     want.d, want.hi, want.c, want.gt, want.lt, want.eq, want.e);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            now = act(sel);
            tests++;
            if (now !== got || vld(sel) !== 1'b1 || rdy(sel) !== 1'b0) begin
                fails++;
                $display("FAIL %s hold%0d: got d=%h valid=%b ready=%b, want d=%h valid=1 ready=0",
                         name, i, now.d, vld(sel), rdy(sel), got.d);
            end
        end
        set_ordy(sel, 1'b1);
        @(negedge clk);
        set_ordy(sel, 1'b0);
        tests++;
        if (rdy(sel) !== 1'b1 || vld(sel) !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake: got ready=%b valid=%b, want ready=1 valid=0", name, rdy(sel), vld(sel));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if (ir8 !== 1'b1 || ir16 !== 1'b1 || ov8 !== 1'b0 || ov16 !== 1'b0 ||
            act(0) !== exp_t'(0) || act(1) !== exp_t'(0)) begin
            fails++;
            $display("FAIL reset_state: got ready=%b/%b valid=%b/%b out8=%h, want ready=1 valid=0 out=0",
                     ir8, ir16, ov8, ov16, act(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b valid=%b, want ready=1 valid=0", ir8, ov8);
        end
    endtask

    task automatic test_add_sub();
        run(0, 4'd0, 16'h00F0, 16'h0020, 1'b0, mk(16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "add");
        run(0, 4'd1, 16'h0005, 16'h0007, 1'b0, mk(16'h00FE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "sub");
        run(0, 4'd0, 16'h00FF, 16'h0000, 1'b1, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "add_cin");
    endtask

    task automatic test_muldiv();
        run(0, 4'd11, 16'h000F, 16'h0011, 1'b0, mk(16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 9, 0, "mul");
        run(0, 4'd11, 16'h00FF, 16'h00FF, 1'b0, mk(16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 9, 0, "mul_max");
        run(0, 4'd12, 16'd100, 16'd7, 1'b0, mk(16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 9, 0, "divu");
        run(0, 4'd12, 16'd5, 16'd0, 1'b0, mk(16'h00FF, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1, 0, "div0");
    endtask

    task automatic test_cmp_hold();
        run(0, 4'd10, 16'd3, 16'd3, 1'b0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1, 0, "cmp_eq");
        run(0, 4'd10, 16'd5, 16'd3, 1'b0, mk(16'd2, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1, 4, "cmp_gt_hold");
        run(0, 4'd10, 16'd3, 16'd5, 1'b0, mk(16'h00FE, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1, 0, "cmp_lt");
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        @(negedge clk);
        drive(0, 1'b1, 4'd11, 16'h000F, 16'h0011, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (act(0) !== exp_t'(0) || ov8 !== 1'b0 || ir8 !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_mul: got d=%h valid=%b ready=%b, want d=0 valid=0 ready=1", d8, ov8, ir8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge clk); if (ov8 || !ir8) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL reset_abandon: got %0d bad cycles, want 0", seen); end
        run(0, 4'd0, 16'h0012, 16'h0034, 1'b1, mk(16'h0047, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "add_after_reset");
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] a, b;
        logic c;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = (i % 6 == 5) ? 8'd0 : 8'($urandom);
            c  = 1'($urandom);
            run(0, op, {8'd0, a}, {8'd0, b}, c, model8(op, a, b, c),
                (op == 4'd11 || (op == 4'd12 && b != 8'd0)) ? 9 : 1, 0, "random");
        end
    endtask

    task automatic test_width16();
        run(1, 4'd8, 16'h8001, 16'd1, 1'b0, mk(16'h0002, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "shl16");
        run(1, 4'd9, 16'h8001, 16'd17, 1'b0, mk(16'h4000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1, 0, "shr16");
        run(1, 4'd14, 16'h1234, 16'h5678, 1'b0, mk(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1, 0, "illegal16");
        run(1, 4'd11, 16'h1234, 16'h0100, 1'b0, mk(16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 17, 0, "mul16");
    endtask

    initial begin
        iv8 = 1'b0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0; or8 = 1'b0;
        iv16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; c16 = 1'b0; or16 = 1'b0;
        test_reset();
        test_add_sub();
        test_muldiv();
        test_cmp_hold();
        test_reset_mid_mul();
        test_random();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
